hdc_feature_packer: RTL and testbench

Upstream front-end stage for `hdc_sensor_fusion`. Accepts quantized per-channel feature samples one at a time from the sensor/feature-extraction path and assembles them into full `TOTAL_NUM_CHANNEL*CHANNEL_WIDTH` feature frames. Frames are delivered to `hdc_sensor_fusion` on its `features_top`/`fin_valid`/`fin_ready` handshake. A two-entry frame buffer lets the next frame fill while the current one waits for the encoder.

---
 rtl/hdc_feature_packer.sv | 148 ++++++++++++++
 tb/tb_hdc_feature_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_feature_packer.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : hdc_feature_packer                                          |
// | Description : Packs per-channel feature samples into full feature frames |
// |               for hdc_sensor_fusion using a two-entry frame buffer, so   |
// |               the next frame fills while the current one waits.          |
// | Option      : FEATURE_PACKER_FRAME_CHECK_EN enables sample_last framing  |
// |               checks, frame_err pulses and the saturating err_count.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

module hdc_feature_packer #(
    parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
    parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNEL_WIDTH-1:0]             sample_in,
    input  logic                                 sample_valid,
    input  logic                                 sample_last,
    output logic                                 sample_ready,
    output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
    output logic                                 fin_valid,
    input  logic                                 fin_ready,
    output logic                                 frame_err,
    output logic [7:0]                           err_count
);

    localparam int c_FRAME_W = NUM_CHANNEL * CHANNEL_WIDTH;
    localparam int c_CNT_W   = $clog2(NUM_CHANNEL);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(NUM_CHANNEL - 1);

    // Frame storage and bookkeeping
    logic [c_FRAME_W-1:0] r_buf [2];
    logic [1:0]           r_full;
    logic                 r_wr_sel;
    logic                 r_rd_sel;
    logic [c_CNT_W-1:0]   r_cnt;

    logic w_accept;     // sample handshake this cycle
    logic w_drain;      // frame handshake this cycle
    logic w_last;       // current sample lands in the final channel slot
    logic w_err;        // accepted sample breaks framing (check build only)
    logic w_complete;   // accepted sample closes a good frame
    logic [1:0] w_full_set;
    logic [1:0] w_full_clr;

    // Ready depends only on registered state, never on sample_valid
    assign sample_ready = ~r_full[r_wr_sel];
    assign fin_valid    = r_full[r_rd_sel];
    assign features_top = r_buf[r_rd_sel];

    assign w_accept = sample_valid & sample_ready;
    assign w_drain  = fin_valid & fin_ready;
    assign w_last   = (r_cnt == c_LAST_CNT);

`ifdef FEATURE_PACKER_FRAME_CHECK_EN
    logic       r_frame_err;
    logic [7:0] r_err_count;

    // Early last or missing last both discard the partial frame
    assign w_err      = w_accept & (sample_last ^ w_last);
    assign w_complete = w_accept & w_last & ~w_err;

    // Error pulse and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_frame_err <= w_err;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign frame_err = r_frame_err;
    assign err_count = r_err_count;
`else
    // Framing flag is ignored; frames close on the channel count alone
    logic w_unused_sample_last;
    assign w_unused_sample_last = sample_last;

    assign w_err      = 1'b0;
    assign w_complete = w_accept & w_last;
    assign frame_err  = 1'b0;
    assign err_count  = 8'd0;
`endif

    // Completion and drain never hit the same buffer: completion needs
    // full[wr_sel]=0 and drain needs full[rd_sel]=1, so both may apply.
    assign w_full_set = {w_complete &  r_wr_sel, w_complete & ~r_wr_sel};
    assign w_full_clr = {w_drain    &  r_rd_sel, w_drain    & ~r_rd_sel};

    // Write each accepted sample into its slot of the buffer being filled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (w_accept) begin
            r_buf[r_wr_sel][r_cnt*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= sample_in;
        end
    end

    // Full flags: set on frame completion, cleared on frame handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // Channel counter and write/read buffer pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last || w_err) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
            if (w_complete) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_drain) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hdc_feature_packer.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : tb_hdc_feature_packer                                       |
// | Description : Self-checking bench for hdc_feature_packer with a frame-    |
// |               level queue model (NUM_CHANNEL=4, CHANNEL_WIDTH=8).        |
// | Option      : FEATURE_PACKER_FRAME_CHECK_EN adds framing-error scenarios |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_hdc_feature_packer;

    localparam int c_NC = 4;
    localparam int c_CW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_CW-1:0]   sample_in;
    logic              sample_valid;
    logic              sample_last;
    logic              sample_ready;
    logic [c_NC*c_CW-1:0] features_top;
    logic              fin_valid;
    logic              fin_ready;
    logic              frame_err;
    logic [7:0]        err_count;

    int checks   = 0;
    int failures = 0;

    // Model state: complete frames awaiting the encoder, and the frame in progress
    logic [c_NC*c_CW-1:0] m_frames[$];
    logic [c_CW-1:0]      m_part[$];
    int                   m_err_cnt   = 0;
    bit                   m_err_pulse = 1'b0;
    int                   fr_pct      = 100;

    always #5 clk = ~clk;

    hdc_feature_packer #(
        .NUM_CHANNEL  (c_NC),
        .CHANNEL_WIDTH(c_CW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_last (sample_last),
        .sample_ready(sample_ready),
        .features_top(features_top),
        .fin_valid   (fin_valid),
        .fin_ready   (fin_ready),
        .frame_err   (frame_err),
        .err_count   (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #1;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        sample_last  = 1'b0;
        fin_ready    = 1'b0;
        m_frames.delete();
        m_part.delete();
        m_err_cnt   = 0;
        m_err_pulse = 1'b0;
        @(negedge clk);
        chk("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
        chk("rst_fin_valid",    {31'd0, fin_valid},    32'd0);
        chk("rst_features_top", features_top,          32'd0);
        chk("rst_frame_err",    {31'd0, frame_err},    32'd0);
        chk("rst_err_count",    {24'd0, err_count},    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: drive, compare against the model at negedge, advance the model
    task automatic step(input bit v, input logic [c_CW-1:0] d, input bit l, output bit accepted);
        bit m_ready;
        bit drained;
        logic [c_NC*c_CW-1:0] frame;
        sample_valid = v;
        sample_in    = d;
        sample_last  = l;
        fin_ready    = ($urandom_range(99) < fr_pct);
        @(negedge clk);
        m_ready = (m_frames.size() < 2);
        chk("sample_ready", {31'd0, sample_ready}, {31'd0, m_ready});
        chk("fin_valid",    {31'd0, fin_valid},    {31'd0, (m_frames.size() > 0)});
        if (m_frames.size() > 0) chk("features_top", features_top, m_frames[0]);
        chk("frame_err",    {31'd0, frame_err},    {31'd0, m_err_pulse});
        chk("err_count",    {24'd0, err_count},    m_err_cnt);
        accepted    = v && m_ready;
        drained     = fin_ready && (m_frames.size() > 0);
        m_err_pulse = 1'b0;
        if (drained) void'(m_frames.pop_front());
        if (accepted) begin
            m_part.push_back(d);
`ifdef FEATURE_PACKER_FRAME_CHECK_EN
            if (l != (m_part.size() == c_NC)) begin
                m_part.delete();
                m_err_pulse = 1'b1;
                if (m_err_cnt < 255) m_err_cnt++;
            end
`endif
            if (m_part.size() == c_NC) begin
                for (int k = 0; k < c_NC; k++) frame[k*c_CW +: c_CW] = m_part[k];
                m_frames.push_back(frame);
                m_part.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one sample until accepted, with a bounded wait
    task automatic send(input logic [c_CW-1:0] d, input bit l);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            step(1'b1, d, l, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input bit rand_gap);
        bit acc;
        for (int i = 0; i < c_NC; i++) begin
            if (rand_gap && $urandom_range(3) == 0) step(1'b0, 8'h00, 1'b0, acc);
            send(8'($urandom), (i == c_NC - 1));
        end
    endtask

    task automatic drain();
        bit acc;
        int n;
        fr_pct = 100;
        n = 0;
        while (m_frames.size() > 0 && n < 50) begin
            step(1'b0, 8'h00, 1'b0, acc);
            n++;
        end
        chk("drain_empty", {31'd0, fin_valid}, 32'd0);
    endtask

    initial begin
        bit acc;

        // Reset state
        do_reset();

        // Single frame with exact expected contents
        fr_pct = 100;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        chk("single_valid", {31'd0, fin_valid}, 32'd1);
        chk("single_data",  features_top,       32'h4433_2211);
        step(1'b0, 8'h00, 1'b0, acc);
        chk("single_gone",  {31'd0, fin_valid}, 32'd0);

        // Backpressure: two frames fill, ninth sample held, then release
        fr_pct = 0;
        for (int f = 0; f < 2; f++) send_frame(1'b0);
        chk("bp_ready_low", {31'd0, sample_ready}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hA5, 1'b0, acc);
        chk("bp_still_low", {31'd0, sample_ready}, 32'd0);
        fr_pct = 100;
        send_frame(1'b0);
        drain();

        // Concurrent fill/drain with random encoder stalls over 20 frames
        fr_pct = 35;
        for (int f = 0; f < 20; f++) send_frame(1'b0);
        drain();
        fr_pct = 60;
        for (int f = 0; f < 10; f++) send_frame(1'b1);
        drain();

        // Streaming with fin_ready tied high
        fr_pct = 100;
        for (int f = 0; f < 5; f++) send_frame(1'b0);
        drain();

`ifdef FEATURE_PACKER_FRAME_CHECK_EN
        // Early last on 2nd sample, then a good frame
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        chk("fc_err_pulse", {31'd0, frame_err}, 32'd1);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b1);
        chk("fc_err_count", {24'd0, err_count}, 32'd1);
        chk("fc_good_data", features_top,       32'h8877_6655);
        drain();
        // Missing last
        for (int i = 0; i < c_NC; i++) send(8'(i), 1'b0);
        drain();
        // Saturation after 300 malformed frames
        for (int i = 0; i < 300; i++) send(8'($urandom), 1'b1);
        step(1'b0, 8'h00, 1'b0, acc);
        chk("fc_err_sat", {24'd0, err_count}, 32'd255);
`else
        // sample_last is ignored in this build
        for (int i = 0; i < c_NC; i++) send(8'(i + 1), (i == 1));
        chk("nofc_data", features_top, 32'h0403_0201);
        drain();
`endif

        // Reset mid-frame: partial data discarded
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        do_reset();
        fr_pct = 100;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b1);
        chk("midrst_data", features_top, 32'hC4C3_C2C1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
